uop_index_gen: RTL and testbench
================================

Name: uop_index_gen

Overview:
- Stage directly downstream of uop_fetch in the GEMM core.
- Takes the micro-op PC and the six loop offsets and reads the micro-op from uop SRAM, which has 1-cycle read latency.
- Decodes the acc/inp/wgt index fields and adds the outer+inner offsets to each.
- Delivers absolute register-file indices to the GEMM datapath through a valid/ready FIFO, so the SRAM read latency and datapath stalls are absorbed without loss.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; legal values 3..16; 3 is the minimum for full throughput.
- UOP_W, 32, micro-op word width; only 32 is supported.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline clear; drops all in-flight and queued entries
- in_valid  in  1  upc/offsets valid this cycle
- in_ready  out  1  block accepts the input this cycle
- in_last  in  1  marks the final uop of the instruction
- upc  in  13  micro-op byte PC; bits [1:0] are ignored
- dst_offset_out  in  11  outer accumulator offset
- src_offset_out  in  11  outer input offset
- wgt_offset_out  in  10  outer weight offset
- dst_offset_in  in  11  inner accumulator offset
- src_offset_in  in  11  inner input offset
- wgt_offset_in  in  10  inner weight offset
- uop_rd_en  out  1  uop SRAM read strobe
- uop_addr  out  11  uop SRAM word address
- uop_rdata  in  32  SRAM read data, valid the cycle after uop_rd_en
- out_valid  out  1  index triple available
- out_ready  in  1  downstream accepts
- acc_idx  out  11  accumulator index
- inp_idx  out  11  input index
- wgt_idx  out  10  weight index
- out_last  out  1  in_last carried through with the entry

Behaviour:
- Reset (rst=0, async):
  - s1_valid=0, FIFO count=0, rd/wr pointers=0.
  - out_valid=0, acc_idx/inp_idx/wgt_idx/out_last=0.
  - uop_rd_en=0.
  - in_ready=1 once rst is released.
- Accept handshake:
  - accept = in_valid & in_ready.
  - uop_rd_en=accept; uop_addr=upc[12:2]. Both are combinational from the inputs.
- in_ready = !flush & ((count + s1_valid) < FIFO_DEPTH).
  - Uses registered state only; there is no combinational path from out_ready to in_ready.
- Stage 1 register: on accept, capture the six offsets and in_last and set s1_valid=1; otherwise s1_valid=0.
- Stage 1 compute, on the cycle after accept, using uop_rdata:
  - acc_idx = uop[10:0] + dst_offset_out + dst_offset_in, mod 2^11.
  - inp_idx = uop[21:11] + src_offset_out + src_offset_in, mod 2^11.
  - wgt_idx = uop[31:22] + wgt_offset_out + wgt_offset_in, mod 2^10.
  - Sums wrap silently; no saturation, no error flag.
- If s1_valid, the computed entry is written into the FIFO unconditionally. The credit rule guarantees space, so an overflow is a design bug; assert on it.
- Output: out_valid = (count != 0); acc_idx/inp_idx/wgt_idx/out_last show the FIFO head.
  - Head is popped on out_valid & out_ready.
  - Outputs are held stable while out_valid=1 and out_ready=0.
- Latency: accept in cycle N → out_valid in cycle N+2 when the FIFO was empty.
- Throughput: 1 entry/cycle sustained when out_ready stays high and FIFO_DEPTH ≥ 3.
- Simultaneous push and pop: count is unchanged; push and pop on an empty FIFO is not possible because the write lands a cycle before it is visible.
- Entries leave the FIFO in strict input order.
- flush=1:
  - Next cycle s1_valid=0, count=0, pointers=0, out_valid=0.
  - Any SRAM read in flight is discarded.
  - in_ready=0 during the flush cycle.
  - A pop in the same cycle is ignored (flush wins).
- Reset asserted mid-operation: all state clears immediately; no partial entry is ever emitted after rst is released.

Decomposition:
- Shared package gemm_pkg holds:
  - widths: ACC_IDX_W=11, INP_IDX_W=11, WGT_IDX_W=10, UPC_W=13, UOP_ADDR_W=11;
  - micro-op field bounds: ACC [10:0], INP [21:11], WGT [31:22];
  - a uop_idx_t struct {acc, inp, wgt, last}.
- One sub-module: uop_idx_fifo, a synchronous FIFO with FIFO_DEPTH and width parameters, async active-low reset, and a flush input.
- The top level holds stage 1 and the credit logic.

Test Plan:
- Single uop:
  - stimulus: upc=0x010, uop_rdata=0x00C0_2805 (acc=5, inp=5, wgt=3), dst/src/wgt offsets out=16/32/8, in=1/2/1.
  - required: uop_addr=4 with uop_rd_en=1 in cycle N; out_valid in N+2 with acc=22, inp=39, wgt=12.
- Wrap:
  - stimulus: acc field=2040 with dst offsets 5+10; wgt field=1020 with wgt offsets 3+4.
  - required: acc_idx=7, wgt_idx=3.
- Streaming:
  - stimulus: 100 back-to-back accepts with out_ready=1, each uop distinct.
  - required: in_ready stays 1; 100 outputs on consecutive cycles, in order; out_last only on the 100th.
- Backpressure:
  - stimulus: out_ready=0 while streaming.
  - required: in_ready drops once count+s1_valid=4; no entry lost or duplicated; after out_ready=1 the 4 held entries drain in order.
- Flush:
  - stimulus: flush with 3 entries queued plus 1 in s1.
  - required: out_valid=0 next cycle; the next accepted uop is the first output seen.
- Reset mid-stream:
  - stimulus: rst=0 asynchronously between clock edges.
  - required: out_valid and uop_rd_en go 0 immediately; after release in_ready=1 and count=0.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared widths, micro-op field layout and index types for the GEMM core.
// calc_idx turns one micro-op word and its loop offsets into absolute indices.
package gemm_pkg;

    localparam int ACC_IDX_W  = 11;
    localparam int INP_IDX_W  = 11;
    localparam int WGT_IDX_W  = 10;
    localparam int UPC_W      = 13;
    localparam int UOP_ADDR_W = 11;
    localparam int UOP_WORD_W = 32;

    localparam int ACC_LSB = 0;
    localparam int ACC_MSB = 10;
    localparam int INP_LSB = 11;
    localparam int INP_MSB = 21;
    localparam int WGT_LSB = 22;
    localparam int WGT_MSB = 31;

    typedef struct packed {
        logic [ACC_IDX_W-1:0] acc;
        logic [INP_IDX_W-1:0] inp;
        logic [WGT_IDX_W-1:0] wgt;
        logic                 last;
    } uop_idx_t;

    localparam int UOP_IDX_W = $bits(uop_idx_t);

    typedef struct packed {
        logic [ACC_IDX_W-1:0] dst_out;
        logic [INP_IDX_W-1:0] src_out;
        logic [WGT_IDX_W-1:0] wgt_out;
        logic [ACC_IDX_W-1:0] dst_in;
        logic [INP_IDX_W-1:0] src_in;
        logic [WGT_IDX_W-1:0] wgt_in;
        logic                 last;
    } uop_off_t;

    // Sums are truncated to the field width, so indices wrap silently.
    function automatic uop_idx_t calc_idx(input logic [UOP_WORD_W-1:0] uop,
                                          input uop_off_t off);
        uop_idx_t r;
        r.acc  = uop[ACC_MSB:ACC_LSB] + off.dst_out + off.dst_in;
        r.inp  = uop[INP_MSB:INP_LSB] + off.src_out + off.src_in;
        r.wgt  = uop[WGT_MSB:WGT_LSB] + off.wgt_out + off.wgt_in;
        r.last = off.last;
        return r;
    endfunction

endpackage

// File: rtl/uop_index_gen_if.sv
// Bundles the upstream request, uop SRAM and downstream index buses of uop_index_gen.
// slave is the block's view; master is the surrounding pipeline / SRAM view.
interface uop_index_gen_if;
    import gemm_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [UPC_W-1:0]      upc;
    logic [ACC_IDX_W-1:0]  dst_offset_out;
    logic [INP_IDX_W-1:0]  src_offset_out;
    logic [WGT_IDX_W-1:0]  wgt_offset_out;
    logic [ACC_IDX_W-1:0]  dst_offset_in;
    logic [INP_IDX_W-1:0]  src_offset_in;
    logic [WGT_IDX_W-1:0]  wgt_offset_in;

    logic                  uop_rd_en;
    logic [UOP_ADDR_W-1:0] uop_addr;
    logic [UOP_WORD_W-1:0] uop_rdata;

    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_IDX_W-1:0]  acc_idx;
    logic [INP_IDX_W-1:0]  inp_idx;
    logic [WGT_IDX_W-1:0]  wgt_idx;
    logic                  out_last;

    modport slave (
        input  in_valid, in_last, upc,
        input  dst_offset_out, src_offset_out, wgt_offset_out,
        input  dst_offset_in, src_offset_in, wgt_offset_in,
        output in_ready,
        output uop_rd_en, uop_addr,
        input  uop_rdata,
        output out_valid, acc_idx, inp_idx, wgt_idx, out_last,
        input  out_ready
    );

    modport master (
        output in_valid, in_last, upc,
        output dst_offset_out, src_offset_out, wgt_offset_out,
        output dst_offset_in, src_offset_in, wgt_offset_in,
        input  in_ready,
        input  uop_rd_en, uop_addr,
        output uop_rdata,
        input  out_valid, acc_idx, inp_idx, wgt_idx, out_last,
        output out_ready
    );

endinterface

// File: rtl/uop_idx_fifo.sv
// Synchronous FIFO with a combinational head, async active-low reset and a synchronous flush.
// Flush has priority over push and pop in the same cycle.
module uop_idx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [W-1:0]                 wdata_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 rdata_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i & valid_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // The upstream credit check must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push_i && !flush_i && !do_pop && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/uop_index_gen.sv
// Reads a micro-op from uop SRAM, adds the outer and inner loop offsets to its three
// index fields and queues the absolute indices for the GEMM datapath.
module uop_index_gen
    import gemm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int UOP_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    uop_index_gen_if.slave  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                 s1_valid_q, s1_valid_d;
    uop_off_t             s1_off_q, s1_off_d;
    logic                 accept;
    logic [CNT_W:0]       credit_used;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_valid;
    logic [UOP_W-1:0]     uop_word;
    uop_idx_t             s1_entry;
    logic [UOP_IDX_W-1:0] fifo_head;
    uop_idx_t             head;

    // Credits count the entry still waiting on SRAM data, so the FIFO can never overflow
    // and out_ready never reaches in_ready combinationally.
    assign credit_used  = {1'b0, fifo_count} + (CNT_W+1)'(s1_valid_q);
    assign bus.in_ready = rst & ~flush & (credit_used < (CNT_W+1)'(FIFO_DEPTH));

    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.uop_rd_en = accept;
    assign bus.uop_addr  = bus.upc[UPC_W-1:2];

    always_comb begin
        s1_valid_d = accept;
        s1_off_d   = s1_off_q;
        if (accept) begin
            s1_off_d.dst_out = bus.dst_offset_out;
            s1_off_d.src_out = bus.src_offset_out;
            s1_off_d.wgt_out = bus.wgt_offset_out;
            s1_off_d.dst_in  = bus.dst_offset_in;
            s1_off_d.src_in  = bus.src_offset_in;
            s1_off_d.wgt_in  = bus.wgt_offset_in;
            s1_off_d.last    = bus.in_last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_off_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_off_q   <= s1_off_d;
        end
    end

    assign uop_word = bus.uop_rdata;
    assign s1_entry = calc_idx(uop_word, s1_off_q);

    uop_idx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UOP_IDX_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (s1_valid_q),
        .wdata_i (s1_entry),
        .pop_i   (bus.out_ready),
        .rdata_o (fifo_head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign head          = uop_idx_t'(fifo_head);
    assign bus.out_valid = fifo_valid;
    assign bus.acc_idx   = head.acc;
    assign bus.inp_idx   = head.inp;
    assign bus.wgt_idx   = head.wgt;
    assign bus.out_last  = head.last;

endmodule

// File: tb/tb_uop_index_gen.sv
// Scoreboard bench for uop_index_gen: the driver queues expected index triples on each
// accept, a negedge monitor pops and compares on every output handshake.
module tb_uop_index_gen;
    import gemm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    uop_index_gen_if bus();

    uop_index_gen #(.FIFO_DEPTH(4), .UOP_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    logic [31:0] sram [0:2047];
    logic [31:0] rdata_q = '0;
    always @(posedge clk) if (bus.uop_rd_en) rdata_q <= sram[bus.uop_addr];
    assign bus.uop_rdata = rdata_q;

    uop_idx_t exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int first_pop = -1;
    int last_pop = -1;
    int stalls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Output monitor
    initial begin
        uop_idx_t a, e;
        forever begin
            @(negedge clk);
            if (rst && !flush && bus.out_valid && bus.out_ready) begin
                a.acc  = bus.acc_idx;
                a.inp  = bus.inp_idx;
                a.wgt  = bus.wgt_idx;
                a.last = bus.out_last;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %0h expected none", a);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_entry", 64'(a), 64'(e));
                end
                pop_cnt++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
    end

    function automatic uop_off_t mk_off(input int dout, sout, wout, din, sin, win,
                                        input logic last);
        uop_off_t o;
        o.dst_out = 11'(dout);
        o.src_out = 11'(sout);
        o.wgt_out = 10'(wout);
        o.dst_in  = 11'(din);
        o.src_in  = 11'(sin);
        o.wgt_in  = 10'(win);
        o.last    = last;
        return o;
    endfunction

    function automatic uop_idx_t mk_idx(input int acc, inp, wgt, input logic last);
        uop_idx_t r;
        r.acc  = 11'(acc);
        r.inp  = 11'(inp);
        r.wgt  = 10'(wgt);
        r.last = last;
        return r;
    endfunction

    task automatic drive_in(input logic [12:0] pc, input uop_off_t o);
        bus.upc            = pc;
        bus.dst_offset_out = o.dst_out;
        bus.src_offset_out = o.src_out;
        bus.wgt_offset_out = o.wgt_out;
        bus.dst_offset_in  = o.dst_in;
        bus.src_offset_in  = o.src_in;
        bus.wgt_offset_in  = o.wgt_in;
        bus.in_last        = o.last;
    endtask

    // Called just after a posedge; returns just after the posedge that accepted it.
    task automatic send(input logic [12:0] pc, input uop_off_t o, input uop_idx_t e);
        int n = 0;
        drive_in(pc, o);
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        stalls += n;
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stuck at 0 for upc %0h", pc);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive_in(13'h0, mk_off(0, 0, 0, 0, 0, 0, 1'b0));
        for (int i = 0; i < 2048; i++) sram[i] = '0;
        sram[4] = 32'h00C0_2805;
        sram[8] = {10'd1020, 11'd0, 11'd2040};
        for (int i = 0; i < 100; i++) sram[100 + i] = {10'(i * 3), 11'(i * 5), 11'(i * 7)};
        for (int i = 0; i < 6; i++) sram[300 + i] = {10'(i), 11'(i + 10), 11'(i + 20)};
        for (int i = 0; i < 4; i++) sram[400 + i] = {10'(i + 1), 11'(i + 2), 11'(i + 3)};
        sram[500] = {10'd77, 11'd66, 11'd55};
        for (int i = 0; i < 3; i++) sram[600 + i] = {10'(i), 11'(i), 11'(i)};
        sram[700] = {10'd9, 11'd8, 11'd7};

        // Reset state, with a request pending to prove the read strobe is gated
        bus.in_valid = 1'b1;
        bus.upc = 13'h010;
        #2;
        chk("rst_rd_en", 64'(bus.uop_rd_en), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_idx", 64'({bus.acc_idx, bus.inp_idx, bus.wgt_idx, bus.out_last}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single uop: strobe and address in N, entry visible in N+2
        drive_in(13'h010, mk_off(16, 32, 8, 1, 2, 1, 1'b0));
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("single_in_ready", 64'(bus.in_ready), 64'd1);
        chk("single_rd_en", 64'(bus.uop_rd_en), 64'd1);
        chk("single_addr", 64'(bus.uop_addr), 64'd4);
        exp_q.push_back(mk_idx(22, 39, 12, 1'b0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_n1_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("lat_n2_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        wait_drain("single_drain");

        // Wrap
        send(13'h020, mk_off(5, 0, 3, 10, 0, 4, 1'b0), mk_idx(7, 0, 3, 1'b0));
        wait_drain("wrap_drain");

        // Streaming, with junk in upc[1:0]
        pop_cnt = 0;
        first_pop = -1;
        stalls = 0;
        for (int i = 0; i < 100; i++)
            send(13'((100 + i) * 4 + (i % 4)), mk_off(100, 200, 50, 1, 2, 3, i == 99),
                 mk_idx(7 * i + 101, 5 * i + 202, 3 * i + 53, i == 99));
        wait_drain("stream_drain");
        chk("stream_stalls", 64'(stalls), 64'd0);
        chk("stream_count", 64'(pop_cnt), 64'd100);
        chk("stream_consecutive", 64'(last_pop - first_pop), 64'd99);

        // Backpressure
        bus.out_ready = 1'b0;
        pop_cnt = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(13'((300 + i) * 4), mk_off(1, 0, 0, 0, 0, 0, i == 5),
                         mk_idx(i + 21, i + 10, i, i == 5));
            end
            begin
                repeat (10) @(negedge clk);
                chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
                chk("bp_accepted", 64'(exp_q.size()), 64'd4);
                chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
                chk("bp_hold_a", 64'(bus.acc_idx), 64'd21);
                @(negedge clk);
                chk("bp_hold_b", 64'({bus.acc_idx, bus.inp_idx, bus.wgt_idx}), 64'({11'd21, 11'd10, 10'd0}));
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("bp_drain");
        chk("bp_count", 64'(pop_cnt), 64'd6);

        // Flush with 3 queued and 1 in stage 1
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(13'((400 + i) * 4), mk_off(0, 0, 0, 0, 0, 0, 1'b0),
                 mk_idx(i + 3, i + 2, i + 1, 1'b0));
        flush = 1'b1;
        bus.out_ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        pop_cnt = 0;
        send(13'(500 * 4), mk_off(0, 0, 0, 0, 0, 0, 1'b1), mk_idx(55, 66, 77, 1'b1));
        wait_drain("flush_drain");
        chk("flush_count", 64'(pop_cnt), 64'd1);

        // Asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(13'((600 + i) * 4), mk_off(0, 0, 0, 0, 0, 0, 1'b0), mk_idx(i, i, i, 1'b0));
        drive_in(13'(610 * 4), mk_off(0, 0, 0, 0, 0, 0, 1'b0));
        bus.in_valid = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_rd_en", 64'(bus.uop_rd_en), 64'd0);
        exp_q.delete();
        bus.in_valid = 1'b0;
        #3;
        rst = 1'b1;
        @(negedge clk);
        chk("arst_rel_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_rel_out_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        pop_cnt = 0;
        send(13'(700 * 4), mk_off(0, 0, 0, 0, 0, 0, 1'b0), mk_idx(7, 8, 9, 1'b0));
        wait_drain("arst_drain");
        chk("arst_count", 64'(pop_cnt), 64'd1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
